// File: rtl/pw_psum_accum_ctrl.sv
// pw_psum_accum_ctrl: multi-pass partial-sum accumulator (tile-buffer read-modify-write, 4-entry output FIFO).
// Define PW_PSUM_SAT_EN for per-lane saturating addition; otherwise lanes wrap modulo 2^ACC_W.
module pw_psum_accum_ctrl #(
  parameter int DEPTH = 128,
  parameter int LANES = 32,
  parameter int ACC_W = 32,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [AW:0]            cfg_rows,
  input  logic [15:0]            cfg_passes,
  output logic                   busy,
  output logic                   done,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*ACC_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*ACC_W-1:0] out_data,
  output logic                   buf_rd_en,
  output logic [AW-1:0]          buf_rd_addr,
  input  logic [LANES*ACC_W-1:0] buf_rd_data,
  input  logic                   buf_rd_valid,
  output logic                   buf_wr_en,
  output logic [AW-1:0]          buf_wr_addr,
  output logic [LANES*ACC_W-1:0] buf_wr_data
);
  localparam int W = LANES*ACC_W;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [AW:0] rows_q, rows_d, row_q, row_d;
  logic [15:0] passes_q, passes_d, pass_q, pass_d;
  logic [2:0] v_q, last_q;
  logic [1:0] rd_q, infl, wp_q, rp_q;
  logic [AW-1:0] a1_q, a2_q, a3_q;
  logic [W-1:0] d1_q, d2_q, d3_q, sum;
  logic [W-1:0] fifo_q [4];
  logic [2:0] cnt_q;
  logic last_pass, row_wrap, hazard, credit_ok, acc, push, pop, unused_rd_valid;
  // Return data is taken purely by pipeline position, so the strobe carries no information.
  assign unused_rd_valid = buf_rd_valid;
  assign last_pass = pass_q == passes_q - 16'd1;
  assign row_wrap = row_q == rows_q - (AW+1)'(1);
  assign hazard = (v_q[0] && a1_q == row_q[AW-1:0]) || (v_q[1] && a2_q == row_q[AW-1:0]) ||
                  (v_q[2] && a3_q == row_q[AW-1:0]);
  assign infl = 2'(v_q[0] & last_q[0]) + 2'(v_q[1] & last_q[1]) + 2'(v_q[2] & last_q[2]);
  assign pop = out_valid && out_ready;
  assign push = v_q[2] && last_q[2];
  // Reserve a FIFO slot for every last-pass beat still in the pipeline.
  assign credit_ok = !last_pass || ({1'b0, cnt_q} + {2'b0, infl} < 4'd4 + {3'b0, pop});
  assign in_ready = state_q == RUN && !hazard && credit_ok;
  assign acc = in_valid && in_ready;
  assign busy = state_q == RUN || state_q == DRAIN;
  assign done = state_q == DONE;
  assign buf_rd_en = acc && pass_q != '0;
  assign buf_rd_addr = buf_rd_en ? row_q[AW-1:0] : '0;
  assign buf_wr_en = v_q[2];
  assign buf_wr_addr = a3_q;
  assign buf_wr_data = d3_q;
  assign out_valid = cnt_q != '0;
  assign out_data = out_valid ? fifo_q[rp_q] : '0;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [ACC_W-1:0] a, b;
    assign a = rd_q[1] ? buf_rd_data[i*ACC_W +: ACC_W] : '0;
    assign b = d2_q[i*ACC_W +: ACC_W];
`ifdef PW_PSUM_SAT_EN
    logic [ACC_W:0] s;
    assign s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    assign sum[i*ACC_W +: ACC_W] = s[ACC_W] != s[ACC_W-1] ? {s[ACC_W], {(ACC_W-1){s[ACC_W-1]}}} : s[ACC_W-1:0];
`else
    assign sum[i*ACC_W +: ACC_W] = a + b;
`endif
  end
  always_comb begin
    state_d = state_q;
    rows_d = rows_q;
    passes_d = passes_q;
    row_d = row_q;
    pass_d = pass_q;
    if (state_q == IDLE && start) begin
      rows_d = cfg_rows;
      passes_d = cfg_passes;
      row_d = '0;
      pass_d = '0;
      state_d = (cfg_rows != '0 && cfg_passes != '0) ? RUN : DONE;
    end else if (acc) begin
      row_d = row_wrap ? '0 : row_q + (AW+1)'(1);
      pass_d = row_wrap ? pass_q + 16'd1 : pass_q;
      state_d = row_wrap && last_pass ? DRAIN : RUN;
    end else if (state_q == DRAIN && v_q == '0 && cnt_q == '0) state_d = DONE;
    else if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      rows_q <= '0;
      passes_q <= '0;
      row_q <= '0;
      pass_q <= '0;
      v_q <= '0;
      last_q <= '0;
      rd_q <= '0;
      a1_q <= '0;
      a2_q <= '0;
      a3_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
      d3_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rows_q <= rows_d;
      passes_q <= passes_d;
      row_q <= row_d;
      pass_q <= pass_d;
      v_q <= {v_q[1:0], acc};
      last_q <= {last_q[1:0], last_pass};
      rd_q <= {rd_q[0], buf_rd_en};
      a1_q <= row_q[AW-1:0];
      a2_q <= a1_q;
      a3_q <= a2_q;
      d1_q <= in_data;
      d2_q <= d1_q;
      d3_q <= sum;
      wp_q <= wp_q + {1'b0, push};
      rp_q <= rp_q + {1'b0, pop};
      cnt_q <= cnt_q + {2'b0, push} - {2'b0, pop};
    end
  always_ff @(posedge clk)
    if (push) fifo_q[wp_q] <= d3_q;
endmodule

// File: tb/tb_pw_psum_accum_ctrl.sv
// tb_pw_psum_accum_ctrl: randomized bench with a lane-arithmetic reference model and a buffer memory model.
module tb_pw_psum_accum_ctrl;
  localparam int DEPTH = 128, LANES = 32, ACC_W = 32, AW = 7, W = LANES*ACC_W;
  logic clk = 0, rst;
  logic start, busy, done, in_valid, in_ready, out_valid, out_ready;
  logic [AW:0] cfg_rows;
  logic [15:0] cfg_passes;
  logic [W-1:0] in_data, out_data, buf_rd_data, buf_wr_data;
  logic buf_rd_en, buf_rd_valid, buf_wr_en;
  logic [AW-1:0] buf_rd_addr, buf_wr_addr;
  always #5 clk = ~clk;

  pw_psum_accum_ctrl #(.DEPTH(DEPTH), .LANES(LANES), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .cfg_passes(cfg_passes),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .buf_rd_valid(buf_rd_valid), .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr),
    .buf_wr_data(buf_wr_data));

  int total = 0, bad = 0;
  task automatic chk(string nm, logic [W-1:0] got, logic [W-1:0] exp);
    int l;
    l = 0;
    total++;
    if (got !== exp) begin
      bad++;
      for (int i = LANES-1; i >= 0; i--) if (got[i*ACC_W +: ACC_W] !== exp[i*ACC_W +: ACC_W]) l = i;
      $display("FAIL %s lane%0d got=%0h want=%0h", nm, l, got[l*ACC_W +: ACC_W], exp[l*ACC_W +: ACC_W]);
    end
  endtask

  function automatic logic [W-1:0] row_of(int v);
    return {LANES{ACC_W'(v)}};
  endfunction

  function automatic logic [W-1:0] add_rows(logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] r;
    longint mx, mn, s;
    mx = (longint'(1) <<< (ACC_W-1)) - 1;
    mn = -mx - 1;
    for (int l = 0; l < LANES; l++) begin
      s = longint'($signed(a[l*ACC_W +: ACC_W])) + longint'($signed(b[l*ACC_W +: ACC_W]));
`ifdef PW_PSUM_SAT_EN
      s = s > mx ? mx : (s < mn ? mn : s);
`endif
      r[l*ACC_W +: ACC_W] = s[ACC_W-1:0];
    end
    return r;
  endfunction

  // Tile buffer: two-cycle read latency, random junk on the return bus otherwise.
  logic [W-1:0] mem [DEPTH];
  logic r1_v = 0, r2_v = 0, junk_v;
  logic [W-1:0] r1_d, r2_d, junk_d;
  always @(posedge clk) begin
    r1_v <= buf_rd_en;
    r1_d <= mem[buf_rd_addr];
    r2_v <= r1_v;
    r2_d <= r1_d;
    if (buf_wr_en) mem[buf_wr_addr] <= buf_wr_data;
  end
  assign buf_rd_valid = r2_v | junk_v;
  assign buf_rd_data = r2_v ? r2_d : junk_d;
  initial begin
    junk_v = 0;
    junk_d = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    forever begin
      @(negedge clk);
      junk_v = $urandom_range(0, 3) == 0;
      for (int l = 0; l < LANES; l++) junk_d[l*ACC_W +: ACC_W] = $urandom;
    end
  end

  // Reference model: beat index -> (row, pass); expected writes land three cycles after acceptance.
  typedef struct {int c; int row; logic [W-1:0] d; bit last;} wr_t;
  wr_t pend[$];
  logic [W-1:0] outq[$], got[$], accm [DEPTH], prev_out, d;
  int acc_cyc[$];
  int cyc = 0, j_rows = 1, j_passes = 1, k = 0, n_acc = 0, n_rd = 0, n_done = 0;
  bit hold_prev = 0;
  initial forever begin
    int row, pass;
    bit hz, exp_wr;
    @(negedge clk);
    #2;
    cyc++;
    if (rst) begin
      pend.delete();
      outq.delete();
      hold_prev = 0;
      continue;
    end
    if (hold_prev) begin
      chk("out_hold_valid", out_valid, 1);
      chk("out_hold_data", out_data, prev_out);
    end
    hold_prev = out_valid && !out_ready;
    prev_out = out_data;
    if (out_valid && out_ready) begin
      if (outq.size() == 0) chk("out_spurious", out_valid, 0);
      else chk("out_data", out_data, outq.pop_front());
      got.push_back(out_data);
    end
    while (pend.size() > 0 && pend[0].c < cyc) void'(pend.pop_front());
    if (in_valid && in_ready) begin
      row = k % j_rows;
      pass = k / j_rows;
      hz = 0;
      foreach (pend[i]) if (pend[i].row == row) hz = 1;
      chk("hazard", hz, 0);
      chk("rd_en", buf_rd_en, pass != 0);
      if (pass != 0) chk("rd_addr", buf_rd_addr, row);
      d = pass == 0 ? in_data : add_rows(accm[row], in_data);
      accm[row] = d;
      pend.push_back('{cyc + 3, row, d, pass == j_passes - 1});
      k++;
      n_acc++;
      acc_cyc.push_back(cyc);
    end else chk("rd_en_idle", buf_rd_en, 0);
    if (buf_rd_en) n_rd++;
    exp_wr = pend.size() > 0 && pend[0].c == cyc;
    chk("wr_en", buf_wr_en, exp_wr);
    if (exp_wr) begin
      chk("wr_addr", buf_wr_addr, pend[0].row);
      chk("wr_data", buf_wr_data, pend[0].d);
      if (pend[0].last) outq.push_back(pend[0].d);
      void'(pend.pop_front());
    end
    chk("ready_outside_busy", in_ready && !busy, 0);
    if (done) begin
      n_done++;
      chk("done_busy", busy, 0);
      chk("done_pend", pend.size(), 0);
      chk("done_outq", outq.size(), 0);
    end
  end

  task automatic rst_chk(string tag);
    chk({tag, "_ctl"}, {in_ready, out_valid, busy, done, buf_rd_en, buf_wr_en, buf_rd_addr, buf_wr_addr}, 0);
    chk({tag, "_wdata"}, buf_wr_data, 0);
    chk({tag, "_odata"}, out_data, 0);
  endtask

  // mode: 0 random, 1 lanes=row+1, 2 lanes=val, 3 max-int pass then 1
  task automatic run_job(int rows, int passes, int mode, int val, bit rv, bit ro, int hold, int abort, bit mid);
    logic [W-1:0] beats[$];
    logic [W-1:0] b;
    int idx, t, n, d0;
    n = rows * passes;
    for (int i = 0; i < n; i++) begin
      for (int l = 0; l < LANES; l++)
        b[l*ACC_W +: ACC_W] = mode == 0 ? $urandom : mode == 1 ? i % rows + 1 : mode == 2 ? val :
                              (i < rows ? 32'h7FFFFFFF : 1);
      beats.push_back(b);
    end
    @(negedge clk);
    got.delete();
    acc_cyc.delete();
    j_rows = rows;
    j_passes = passes;
    k = 0;
    d0 = n_done;
    start = 1;
    cfg_rows = (AW+1)'(rows);
    cfg_passes = 16'(passes);
    out_ready = 1;
    @(negedge clk);
    start = 0;
    idx = 0;
    t = 0;
    while (idx < n && t < 4000) begin
      in_valid = rv ? $urandom_range(0, 9) < 7 : 1;
      in_data = beats[idx];
      out_ready = (t <= hold && hold > 0) ? 0 : (ro ? $urandom_range(0, 1) : 1);
      start = mid && t == 5;
      if (start) begin
        cfg_rows = 3;
        cfg_passes = 1;
      end
      #1;
      if (hold > 0 && t == hold) begin
        chk("hold_accepts", idx, 4);
        chk("hold_ready_low", in_ready, 0);
      end
      if (abort > 0 && idx == abort) begin
        in_valid = 0;
        #2;
        rst = 1;
        #1;
        rst_chk("abort");
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        return;
      end
      if (in_valid && in_ready) idx++;
      @(negedge clk);
      t++;
    end
    chk("beats_timeout", idx, n);
    in_valid = 0;
    start = 0;
    t = 0;
    while (n_done == d0 && t < 4000) begin
      @(negedge clk);
      out_ready = ro ? $urandom_range(0, 1) : 1;
      t++;
    end
    repeat (2) @(negedge clk);
    chk("done_once", n_done - d0, 1);
  endtask

  task automatic chk_rows(string nm, int n, int v0, int step);
    chk({nm, "_nout"}, got.size(), n);
    for (int i = 0; i < got.size() && i < n; i++) chk({nm, "_row"}, got[i], row_of(v0 + i * step));
  endtask

  initial begin
    int r0, a0;
    rst = 1;
    start = 0;
    cfg_rows = 0;
    cfg_passes = 0;
    in_valid = 0;
    in_data = '0;
    out_ready = 0;
    repeat (2) @(negedge clk);
    rst_chk("reset");
    rst = 0;
    r0 = n_rd;
    run_job(4, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("p1_rd_count", n_rd - r0, 0);
    chk_rows("p1", 4, 1, 1);
    run_job(8, 3, 2, 5, 0, 0, 0, 0, 0);
    chk_rows("p3", 8, 15, 0);
    chk("p3_nacc", acc_cyc.size(), 24);
    if (acc_cyc.size() == 24) chk("p3_b2b", acc_cyc[23] - acc_cyc[0], 23);
    run_job(1, 4, 2, 1, 0, 0, 0, 0, 0);
    chk_rows("p25", 1, 4, 0);
    for (int i = 0; i + 1 < acc_cyc.size(); i++) chk("p25_gap", acc_cyc[i+1] - acc_cyc[i], 4);
    run_job(1, 2, 3, 0, 0, 0, 0, 0, 0);
`ifdef PW_PSUM_SAT_EN
    chk_rows("p26", 1, 32'h7FFFFFFF, 0);
`else
    chk_rows("p26", 1, 32'h80000000, 0);
`endif
    run_job(8, 1, 1, 0, 0, 0, 20, 0, 0);
    chk_rows("p27", 8, 1, 1);
    a0 = n_acc;
    run_job(0, 3, 0, 0, 0, 0, 0, 0, 0);
    run_job(5, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("zero_cfg_nacc", n_acc - a0, 0);
    for (int j = 0; j < 8; j++)
      run_job($urandom_range(1, 12), $urandom_range(1, 4), 0, 0, 1, 1, 0, 0, 1);
    run_job(DEPTH, 2, 0, 0, 1, 1, 0, 0, 0);
    run_job(6, 3, 0, 0, 0, 1, 0, 8, 0);
    r0 = n_rd;
    run_job(4, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("p28_rd_count", n_rd - r0, 0);
    chk_rows("p28", 4, 1, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
